// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
package display_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        GUARD = 1'b1
    } scan_state_t;

    localparam int MAX_DIGITS = 8;

    // Clock cycles in one full scan of all digits including guard slots.
    function automatic int frame_len(input int ndigits, input int divbits, input int guard);
        return ndigits * ((1 << divbits) + guard);
    endfunction

    localparam int DEFAULT_FRAME_LEN = frame_len(4, 16, 4);

    // Bit i set means digit i is a leading zero that should stay dark.
    // Digit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] blank_mask(
        input logic [4*MAX_DIGITS-1:0] digits,
        input int                      ndigits,
        input logic                    lzb
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < ndigits) begin
                all_zero = all_zero && (digits[4*i +: 4] == 4'h0);
                mask[i]  = lzb && (i != 0) && all_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot timer: counts while enabled, flags the last count of a slot.
module scan_prescaler #(
    parameter int DIVBITS = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [DIVBITS-1:0] cnt_reg;

    // Counter wraps naturally from all-ones to zero, so a slot is exactly 2**DIVBITS cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tc = en && (cnt_reg == '1);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed hex display scanner with guard gaps, double buffering
// and leading-zero blanking.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int DIVBITS      = 16,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    input  logic                   lzb_en,
    output logic [3:0]             data,
    output logic [NDIGITS-1:0]     digit_en,
    output logic                   frame_start
);

    localparam int IW = $clog2(NDIGITS);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [IW-1:0] ILAST = IW'(NDIGITS - 1);
    localparam logic [GW-1:0] GLAST = GW'(GUARD_CYCLES - 1);

    scan_state_t          state_reg, state_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic [GW-1:0]        gcnt_reg, gcnt_next;
    logic [4*NDIGITS-1:0] shadow_reg, shadow_next;
    logic [4*NDIGITS-1:0] pending_reg, pending_next;
    logic                 pend_valid_reg, pend_valid_next;
    logic                 frame_start_reg, frame_start_next;
    logic                 lzb_reg;
    logic                 tc;
    logic [MAX_DIGITS-1:0] blank;
    logic [3:0]           nibble;

    scan_prescaler #(
        .DIVBITS (DIVBITS)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_reg == SHOW),
        .clr     (state_reg == GUARD),
        .tc      (tc)
    );

    // State register; lzb_en is registered so no input reaches the outputs combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= SHOW;
            idx_reg         <= '0;
            gcnt_reg        <= '0;
            shadow_reg      <= '0;
            pending_reg     <= '0;
            pend_valid_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            lzb_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            gcnt_reg        <= gcnt_next;
            shadow_reg      <= shadow_next;
            pending_reg     <= pending_next;
            pend_valid_reg  <= pend_valid_next;
            frame_start_reg <= frame_start_next;
            lzb_reg         <= lzb_en;
        end
    end

    // Next-state: slot sequencing, frame-boundary buffer swap, and load capture.
    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        gcnt_next        = gcnt_reg;
        shadow_next      = shadow_reg;
        pending_next     = pending_reg;
        pend_valid_next  = pend_valid_reg;
        frame_start_next = 1'b0;
        case (state_reg)
            SHOW: begin
                if (tc) begin
                    state_next = GUARD;
                    gcnt_next  = '0;
                end
            end
            GUARD: begin
                if (gcnt_reg == GLAST) begin
                    state_next = SHOW;
                    gcnt_next  = '0;
                    if (idx_reg == ILAST) begin
                        idx_next         = '0;
                        frame_start_next = 1'b1;
                        if (pend_valid_reg) begin
                            shadow_next     = pending_reg;
                            pend_valid_next = 1'b0;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    gcnt_next = gcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = SHOW;
            end
        endcase
        // A load on the boundary edge wins over the clear, so it is shown a frame later.
        if (load) begin
            pending_next    = value;
            pend_valid_next = 1'b1;
        end
    end

    assign blank  = blank_mask((4*MAX_DIGITS)'(shadow_reg), NDIGITS, lzb_reg);
    assign nibble = shadow_reg[{idx_reg, 2'b00} +: 4];

    // Output decode: enable only during SHOW of an unblanked digit; data held through GUARD.
    always_comb begin
        data     = blank[idx_reg] ? 4'h0 : nibble;
        digit_en = '0;
        if (state_reg == SHOW && !blank[idx_reg]) begin
            digit_en = NDIGITS'(1) << idx_reg;
        end
    end

    assign frame_start = frame_start_reg;

endmodule
